operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 21 ++
 rtl/operand_fetch.sv | 50 +++++
 tb/tb_operand_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Operand-fetch bundle: decode/write-back inputs and the three read operands.
interface operand_fetch_if;
  logic [15:0] IR;
  logic [15:0] BUS;
  logic        LD_REG;
  logic        DRMUX;
  logic        SR1MUX;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;
  logic [15:0] ALU_B;

  modport master (
    output IR, BUS, LD_REG, DRMUX, SR1MUX,
    input  SR1_OUT, SR2_OUT, ALU_B
  );

  modport slave (
    input  IR, BUS, LD_REG, DRMUX, SR1MUX,
    output SR1_OUT, SR2_OUT, ALU_B
  );
endinterface

// File: rtl/operand_fetch.sv
// Eight-entry 16-bit register file with two combinational read ports and an
// ALU operand-B mux selecting between SR2 and the sign-extended imm5 field.
module operand_fetch (
  input  logic            Clk,
  input  logic            Reset,
  operand_fetch_if.slave  of_if
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];
  logic [2:0]  dr_sel;
  logic [2:0]  sr1_sel;
  logic [2:0]  sr2_sel;
  logic [15:0] imm_ext;
  logic        unused_opcode;

  assign unused_opcode = ^of_if.IR[15:12];

  assign dr_sel  = of_if.DRMUX  ? 3'b111          : of_if.IR[11:9];
  assign sr1_sel = of_if.SR1MUX ? of_if.IR[8:6]   : of_if.IR[11:9];
  assign sr2_sel = of_if.IR[2:0];
  assign imm_ext = {{11{of_if.IR[4]}}, of_if.IR[4:0]};

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (of_if.LD_REG) begin
      regs_d[dr_sel] = of_if.BUS;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Reads come straight from the flops, so a pending write stays invisible until after the edge.
  assign of_if.SR1_OUT = regs_q[sr1_sel];
  assign of_if.SR2_OUT = regs_q[sr2_sel];
  assign of_if.ALU_B   = of_if.IR[5] ? imm_ext : regs_q[sr2_sel];

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// traffic against an array-based register model.
module tb_operand_fetch;

  logic Clk;
  logic Reset;
  operand_fetch_if ifc ();

  operand_fetch dut (
    .Clk   (Clk),
    .Reset (Reset),
    .of_if (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [15:0] model [8];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] exp_sr1();
    return ifc.SR1MUX ? model[ifc.IR[8:6]] : model[ifc.IR[11:9]];
  endfunction

  function automatic logic [15:0] exp_sr2();
    return model[ifc.IR[2:0]];
  endfunction

  function automatic logic [15:0] exp_alub();
    int v;
    if (ifc.IR[5]) begin
      v = int'(ifc.IR[4:0]);
      if (v > 15) v = v - 32;
      return 16'(v);
    end
    return model[ifc.IR[2:0]];
  endfunction

  function automatic logic [15:0] mk_ir(input int dr, input int sr1, input int imm, input int low5);
    logic [15:0] ir;
    ir = 16'h0000;
    ir[11:9] = 3'(dr);
    ir[8:6]  = 3'(sr1);
    ir[5]    = 1'(imm);
    ir[4:0]  = 5'(low5);
    return ir;
  endfunction

  // Rising edge: update the model from the values the bench is driving.
  task automatic step();
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    end else if (ifc.LD_REG) begin
      model[ifc.DRMUX ? 7 : int'(ifc.IR[11:9])] = ifc.BUS;
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    Reset = 1'b0; ifc.LD_REG = 1'b0; ifc.DRMUX = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ifc.LD_REG = 1'b1; ifc.BUS = 16'hDEAD; ifc.DRMUX = 1'b0;
    ifc.SR1MUX = 1'b0; ifc.IR = 16'h0000;
    step(); step();
    idle();
    for (int m = 0; m < 2; m++) begin
      ifc.SR1MUX = 1'(m); ifc.IR = 16'h0000;
      #1;
      checks++;
      if (ifc.SR1_OUT !== 16'h0000) begin failures++; $display("FAIL reset_sr1 mux=%0d got=%h exp=0000", m, ifc.SR1_OUT); end
      checks++;
      if (ifc.SR2_OUT !== 16'h0000) begin failures++; $display("FAIL reset_sr2 mux=%0d got=%h exp=0000", m, ifc.SR2_OUT); end
      checks++;
      if (ifc.ALU_B !== 16'h0000) begin failures++; $display("FAIL reset_alub mux=%0d got=%h exp=0000", m, ifc.ALU_B); end
    end
  endtask

  task automatic test_read_during_write();
    ifc.IR = mk_ir(3, 0, 0, 0); ifc.SR1MUX = 1'b0; ifc.DRMUX = 1'b0;
    ifc.BUS = 16'h1234; ifc.LD_REG = 1'b1;
    #1;
    checks++;
    if (ifc.SR1_OUT !== 16'h0000) begin failures++; $display("FAIL rdw_old got=%h exp=0000", ifc.SR1_OUT); end
    step();
    idle();
    ifc.IR = mk_ir(0, 3, 0, 0); ifc.SR1MUX = 1'b1;
    #1;
    checks++;
    if (ifc.SR1_OUT !== 16'h1234) begin failures++; $display("FAIL rdw_new got=%h exp=1234", ifc.SR1_OUT); end
  endtask

  task automatic test_imm();
    logic [4:0]  imm_v [3];
    logic [15:0] imm_e [3];
    imm_v = '{5'b11111, 5'b10000, 5'b01111};
    imm_e = '{16'hFFFF, 16'hFFF0, 16'h000F};
    ifc.IR = mk_ir(2, 0, 0, 0); ifc.BUS = 16'hABCD; ifc.LD_REG = 1'b1;
    step();
    idle();
    ifc.IR = mk_ir(0, 0, 0, 2);
    #1;
    checks++;
    if (ifc.ALU_B !== 16'hABCD) begin failures++; $display("FAIL imm_reg_path got=%h exp=abcd", ifc.ALU_B); end
    for (int k = 0; k < 3; k++) begin
      ifc.IR = mk_ir(0, 0, 1, int'(imm_v[k]));
      ifc.IR[2:0] = 3'd2;
      if (imm_v[k][2:0] != 3'd2) ifc.IR[4:0] = imm_v[k];
      #1;
      checks++;
      if (ifc.ALU_B !== exp_alub() || exp_alub() !== imm_e[k])
        begin failures++; $display("FAIL imm_ext imm=%b got=%h exp=%h", imm_v[k], ifc.ALU_B, imm_e[k]); end
      checks++;
      if (ifc.SR2_OUT !== exp_sr2())
        begin failures++; $display("FAIL imm_sr2 imm=%b got=%h exp=%h", imm_v[k], ifc.SR2_OUT, exp_sr2()); end
    end
  endtask

  task automatic test_drmux_r7();
    ifc.IR = mk_ir(0, 0, 0, 0); ifc.DRMUX = 1'b1; ifc.BUS = 16'h3001; ifc.LD_REG = 1'b1;
    step();
    idle();
    ifc.IR = mk_ir(0, 0, 0, 7); ifc.SR1MUX = 1'b0;
    #1;
    checks++;
    if (ifc.SR2_OUT !== 16'h3001) begin failures++; $display("FAIL drmux_r7 got=%h exp=3001", ifc.SR2_OUT); end
    checks++;
    if (ifc.SR1_OUT !== 16'h0000) begin failures++; $display("FAIL drmux_r0 got=%h exp=0000", ifc.SR1_OUT); end
  endtask

  task automatic test_reset_priority();
    for (int r = 0; r < 8; r++) begin
      ifc.IR = mk_ir(r, 0, 0, 0); ifc.BUS = 16'(16'h1000 + r); ifc.LD_REG = 1'b1;
      step();
    end
    Reset = 1'b1; ifc.LD_REG = 1'b1; ifc.BUS = 16'h5555; ifc.IR = mk_ir(4, 0, 0, 0);
    step();
    idle();
    for (int r = 0; r < 8; r++) begin
      ifc.IR = mk_ir(r, 0, 0, r); ifc.SR1MUX = 1'b0;
      #1;
      checks++;
      if (ifc.SR1_OUT !== 16'h0000 || ifc.SR2_OUT !== 16'h0000)
        begin failures++; $display("FAIL reset_prio r%0d got=%h/%h exp=0000", r, ifc.SR1_OUT, ifc.SR2_OUT); end
    end
  endtask

  task automatic test_all_regs();
    logic [15:0] vals [8];
    for (int r = 0; r < 8; r++) begin
      vals[r] = {3'(r), 13'($urandom)};
      ifc.IR = mk_ir(r, 0, 0, 0); ifc.BUS = vals[r]; ifc.LD_REG = 1'b1;
      step();
    end
    idle();
    for (int r = 0; r < 8; r++) begin
      ifc.IR = mk_ir(r, 0, 0, r); ifc.SR1MUX = 1'b0;
      #1;
      checks++;
      if (ifc.SR1_OUT !== vals[r]) begin failures++; $display("FAIL allregs_sr1_m0 r%0d got=%h exp=%h", r, ifc.SR1_OUT, vals[r]); end
      checks++;
      if (ifc.SR2_OUT !== vals[r] || ifc.SR1_OUT !== ifc.SR2_OUT)
        begin failures++; $display("FAIL allregs_sr2 r%0d got=%h exp=%h", r, ifc.SR2_OUT, vals[r]); end
      ifc.IR = mk_ir(7 - r, r, 0, 0); ifc.SR1MUX = 1'b1;
      #1;
      checks++;
      if (ifc.SR1_OUT !== vals[r]) begin failures++; $display("FAIL allregs_sr1_m1 r%0d got=%h exp=%h", r, ifc.SR1_OUT, vals[r]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      Reset      = ($urandom_range(0, 19) == 0);
      ifc.LD_REG = 1'($urandom);
      ifc.DRMUX  = ($urandom_range(0, 3) == 0);
      ifc.SR1MUX = 1'($urandom);
      ifc.IR     = 16'($urandom);
      ifc.BUS    = 16'($urandom);
      #1;
      checks++;
      if (ifc.SR1_OUT !== exp_sr1()) begin failures++; $display("FAIL rand_sr1 n=%0d ir=%h got=%h exp=%h", n, ifc.IR, ifc.SR1_OUT, exp_sr1()); end
      checks++;
      if (ifc.SR2_OUT !== exp_sr2()) begin failures++; $display("FAIL rand_sr2 n=%0d ir=%h got=%h exp=%h", n, ifc.IR, ifc.SR2_OUT, exp_sr2()); end
      checks++;
      if (ifc.ALU_B !== exp_alub()) begin failures++; $display("FAIL rand_alub n=%0d ir=%h got=%h exp=%h", n, ifc.IR, ifc.ALU_B, exp_alub()); end
      step();
    end
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    ifc.IR = 16'h0000; ifc.BUS = 16'h0000;
    ifc.LD_REG = 1'b0; ifc.DRMUX = 1'b0; ifc.SR1MUX = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    test_reset();
    test_read_during_write();
    test_imm();
    test_drmux_r7();
    test_reset_priority();
    test_all_regs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
